// File: rtl/pr_arb_pkg.sv
// Shared types and constants for the PageRank read-channel arbiter.
// Requester slots and the registered AR request bundle.
package pr_arb_pkg;

  localparam int REQ_NUM_DEF = 4;
  localparam int REQ_IDX_W = $clog2(REQ_NUM_DEF);

  localparam int REQ_EDGE  = 0;
  localparam int REQ_VERT  = 1;
  localparam int REQ_OFFS  = 2;
  localparam int REQ_SPARE = 3;

  localparam int AR_ADDR_W = 64;

  typedef struct packed {
    logic [AR_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
  } ar_req_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pr_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i,
// wrapping modulo N; returns one-hot grant and its index.
module pr_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pr_rd_arbiter.sv
// Shares one AXI4 read channel among NUM_REQ requesters:
// round-robin AR with credit limits, RID-routed R beats.
module pr_rd_arbiter
  import pr_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  input  logic [NUM_REQ*3-1:0]      req_arsize,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [1:0]                req_rresp,
  output logic                      req_rlast,
  output logic [ID_W-1:0]           arid_m,
  output logic [ADDR_W-1:0]         araddr_m,
  output logic [7:0]                arlen_m,
  output logic [2:0]                arsize_m,
  output logic                      arvalid_m,
  input  logic                      arready_m,
  input  logic [ID_W-1:0]           rid_m,
  input  logic [DATA_W-1:0]         rdata_m,
  input  logic [1:0]                rresp_m,
  input  logic                      rlast_m,
  input  logic                      rvalid_m,
  output logic                      rready_m,
  output logic                      busy,
  output logic                      err_bad_rid
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  logic [NUM_REQ-1:0][7:0] cnt_q, cnt_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic                    arv_q, arv_d;
  logic [ID_W-1:0]         arid_q, arid_d;
  ar_req_t                 ar_q, ar_d;
  logic                    err_q, err_d;

  logic               slot_free;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               gany;

  logic [IW-1:0]      rid_idx;
  logic               mapped;
  logic               last_hs;
  logic [NUM_REQ-1:0] nz;
  logic [NUM_REQ-1:0] dec_v;
  logic [NUM_REQ-1:0] dec_ok;
  logic               bad_dec;

  assign slot_free = !arv_q || arready_m;

  always_comb begin
    elig = '0;
    nz   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nz[i]   = cnt_q[i] != 8'd0;
      elig[i] = req_arvalid[i] && (cnt_q[i] < MAX_CNT);
    end
  end

  pr_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (elig & {NUM_REQ{slot_free}}),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign req_arready = gnt;

  assign rid_idx = rid_m[IW-1:0];
  assign mapped  = ((rid_m >> IW) == '0)
                && (int'(rid_idx) < NUM_REQ);

  // Unmapped beats are swallowed so the memory side never stalls.
  always_comb begin
    req_rvalid = '0;
    rready_m   = 1'b1;
    if (mapped) begin
      req_rvalid[rid_idx] = rvalid_m;
      rready_m            = req_rready[rid_idx];
    end
  end

  assign req_rdata = rdata_m;
  assign req_rresp = rresp_m;
  assign req_rlast = rlast_m;

  assign last_hs = rvalid_m && rready_m
                && rlast_m && mapped;

  always_comb begin
    dec_v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_v[i] = last_hs && (rid_idx == IW'(i));
    end
  end

  assign dec_ok  = dec_v & nz;
  assign bad_dec = |(dec_v & ~nz);

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      unique case (1'b1)
        gnt[i] && !dec_ok[i]: cnt_d[i] = cnt_q[i] + 8'd1;
        !gnt[i] && dec_ok[i]: cnt_d[i] = cnt_q[i] - 8'd1;
        default:              cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign err_d = err_q
              || (rvalid_m && !mapped)
              || bad_dec;

  always_comb begin
    arv_d  = arv_q;
    arid_d = arid_q;
    ar_d   = ar_q;
    ptr_d  = ptr_q;
    if (slot_free) begin
      arv_d = gany;
      if (gany) begin
        arid_d  = ID_W'(gidx);
        ar_d.addr = AR_ADDR_W'(
          req_araddr[int'(gidx)*ADDR_W +: ADDR_W]);
        ar_d.len  = req_arlen[int'(gidx)*8 +: 8];
        ar_d.size = req_arsize[int'(gidx)*3 +: 3];
        ptr_d = IW'((int'(gidx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      arv_q  <= 1'b0;
      arid_q <= '0;
      ar_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      arv_q  <= arv_d;
      arid_q <= arid_d;
      ar_q   <= ar_d;
      err_q  <= err_d;
    end
  end

  assign arvalid_m   = arv_q;
  assign arid_m      = arid_q;
  assign araddr_m    = ADDR_W'(ar_q.addr);
  assign arlen_m     = ar_q.len;
  assign arsize_m    = ar_q.size;
  assign err_bad_rid = err_q;
  assign busy        = arv_q || (|nz);

endmodule
